// File: rtl/command_issue_fsm_pkg.sv
// Shared definitions for the command issue FSM: opcodes, command word layout,
// FSM state encoding and counter sizing.
package command_issue_fsm_pkg;

    localparam logic [7:0] OP_STP = 8'd0;
    localparam logic [7:0] OP_EVP = 8'd1;
    localparam logic [7:0] OP_EVB = 8'd2;
    localparam logic [7:0] OP_RST = 8'd3;

    // Command word layout: {arg2[4:0], arg1[2:0], opcode[7:0]}
    localparam int CMD_OPC_LSB  = 0;
    localparam int CMD_ARG1_LSB = 8;
    localparam int CMD_ARG2_LSB = 11;
    localparam int CMD_W        = 16;

    function automatic int log2(input int value);
        int r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Largest payload is STP with N=31, i.e. 32 words.
    localparam int MAX_PAYLOAD = 32;
    localparam int CNT_W       = log2(MAX_PAYLOAD) + 1;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_CMD,
        S_WR_DATA,
        S_RD_WAIT,
        S_RD_EN,
        S_RD_CAP,
        S_RESP
    } state_t;

    typedef struct packed {
        logic [CMD_W-1:0] word;
        cnt_t             pay;
        cnt_t             resp;
        logic             illegal;
    } cmd_dec_t;

endpackage

// File: rtl/command_issue_fsm_cmd_encoder.sv
// Combinational descriptor decode: command word, payload/response counts and
// the illegal-opcode flag.
module command_issue_fsm_cmd_encoder
    import command_issue_fsm_pkg::*;
(
    input  logic [7:0] opcode,
    input  logic [2:0] arg1,
    input  logic [4:0] arg2,
    output cmd_dec_t   dec
);

    always_comb begin
        // NOTE: every field gets a default first so no path can infer a latch.
        dec = '0;
        dec.word[CMD_OPC_LSB  +: 8] = opcode;
        dec.word[CMD_ARG1_LSB +: 3] = arg1;
        dec.word[CMD_ARG2_LSB +: 5] = arg2;
        case (opcode)
            OP_STP: begin
                dec.pay  = cnt_t'(arg2) + cnt_t'(1);
                dec.resp = cnt_t'(1);
            end
            OP_EVP: begin
                dec.pay  = cnt_t'(1);
                dec.resp = cnt_t'(1);
            end
            OP_EVB: begin
                dec.pay  = cnt_t'(arg2);
                dec.resp = cnt_t'(arg2);
            end
            OP_RST: begin
                dec.pay  = '0;
                dec.resp = '0;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/command_issue_fsm.sv
// Host-side command issuer: writes one encoded command plus its payload into
// the input FIFOs, then collects the expected result/status pairs.
module command_issue_fsm
    import command_issue_fsm_pkg::*;
#(
    parameter int word_size   = 16,
    parameter int buffer_size = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   host_valid,
    output logic                   host_ready,
    input  logic [7:0]             host_opcode,
    input  logic [2:0]             host_arg1,
    input  logic [4:0]             host_arg2,
    input  logic                   pl_valid,
    output logic                   pl_ready,
    input  logic [word_size-1:0]   pl_data,
    input  logic [word_size-1:0]   pop_in_fifo_command,
    input  logic [word_size-1:0]   pop_in_fifo_data,
    output logic                   wr_en_fifo_command,
    output logic                   wr_en_fifo_data,
    output logic [word_size-1:0]   command_out,
    output logic [word_size-1:0]   data_out,
    input  logic [word_size-1:0]   pop_out_fifo,
    output logic                   rd_en_output_fifo,
    input  logic [2*word_size-1:0] result_in,
    input  logic [2*word_size-1:0] status_in,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [2*word_size-1:0] resp_result,
    output logic [2*word_size-1:0] resp_status,
    output logic                   busy,
    output logic                   err_opcode
);

    localparam logic [word_size-1:0] FULL_LVL = word_size'(buffer_size);

    state_t                 state_q, state_d;
    cnt_t                   pay_cnt_q, pay_cnt_d;
    cnt_t                   resp_cnt_q, resp_cnt_d;
    logic [CMD_W-1:0]       cmd_word_q, cmd_word_d;
    logic                   illegal_q, illegal_d;
    logic                   init_q;

    logic                   wr_cmd_q, wr_cmd_d;
    logic                   wr_data_q, wr_data_d;
    logic [word_size-1:0]   command_out_q, command_out_d;
    logic [word_size-1:0]   data_out_q, data_out_d;
    logic                   rd_en_q, rd_en_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [2*word_size-1:0] resp_result_q, resp_result_d;
    logic [2*word_size-1:0] resp_status_q, resp_status_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;

    cmd_dec_t dec;
    logic     cmd_space;

    command_issue_fsm_cmd_encoder u_cmd_encoder (
        .opcode (host_opcode),
        .arg1   (host_arg1),
        .arg2   (host_arg2),
        .dec    (dec)
    );

    assign cmd_space  = pop_in_fifo_command < FULL_LVL;
    // init_q keeps host_ready low until the first clock after reset release.
    assign host_ready = init_q && (state_q == S_IDLE);
    assign pl_ready   = (state_q == S_WR_DATA) && pl_valid && (pop_in_fifo_data < FULL_LVL);

    always_comb begin
        state_d       = state_q;
        pay_cnt_d     = pay_cnt_q;
        resp_cnt_d    = resp_cnt_q;
        cmd_word_d    = cmd_word_q;
        illegal_d     = illegal_q;
        wr_cmd_d      = 1'b0;
        wr_data_d     = 1'b0;
        rd_en_d       = 1'b0;
        err_d         = 1'b0;
        command_out_d = command_out_q;
        data_out_d    = data_out_q;
        resp_result_d = resp_result_q;
        resp_status_d = resp_status_q;

        case (state_q)
            S_IDLE: begin
                if (host_ready && host_valid) begin
                    cmd_word_d = dec.word;
                    illegal_d  = dec.illegal;
                    pay_cnt_d  = dec.pay;
                    resp_cnt_d = dec.resp;
                    state_d    = S_WR_CMD;
                    if (cmd_space) begin
                        wr_cmd_d      = 1'b1;
                        command_out_d = word_size'(dec.word);
                        err_d         = dec.illegal;
                    end
                end
            end
            // The strobe is registered, so WR_CMD is left in the cycle it is high.
            S_WR_CMD: begin
                if (wr_cmd_q) begin
                    if (pay_cnt_q != '0)       state_d = S_WR_DATA;
                    else if (resp_cnt_q != '0) state_d = S_RD_WAIT;
                    else                       state_d = S_IDLE;
                end else if (cmd_space) begin
                    wr_cmd_d      = 1'b1;
                    command_out_d = word_size'(cmd_word_q);
                    err_d         = illegal_q;
                end
            end
            S_WR_DATA: begin
                if (pl_ready) begin
                    wr_data_d  = 1'b1;
                    data_out_d = pl_data;
                    pay_cnt_d  = pay_cnt_q - cnt_t'(1);
                    if (pay_cnt_q == cnt_t'(1))
                        state_d = (resp_cnt_q != '0) ? S_RD_WAIT : S_IDLE;
                end
            end
            S_RD_WAIT: begin
                if (pop_out_fifo != '0) begin
                    state_d = S_RD_EN;
                    rd_en_d = 1'b1;
                end
            end
            S_RD_EN:  state_d = S_RD_CAP;
            S_RD_CAP: begin
                resp_result_d = result_in;
                resp_status_d = status_in;
                state_d       = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_cnt_d = resp_cnt_q - cnt_t'(1);
                    state_d    = (resp_cnt_q == cnt_t'(1)) ? S_IDLE : S_RD_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        resp_valid_d = (state_d == S_RESP);
        busy_d       = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values and ordering between blocks cannot matter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            pay_cnt_q     <= '0;
            resp_cnt_q    <= '0;
            cmd_word_q    <= '0;
            illegal_q     <= 1'b0;
            init_q        <= 1'b0;
            wr_cmd_q      <= 1'b0;
            wr_data_q     <= 1'b0;
            command_out_q <= '0;
            data_out_q    <= '0;
            rd_en_q       <= 1'b0;
            resp_valid_q  <= 1'b0;
            // NOTE: data registers are reset too because they are visible outputs
            // whose reset value the host relies on.
            resp_result_q <= '0;
            resp_status_q <= '0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pay_cnt_q     <= pay_cnt_d;
            resp_cnt_q    <= resp_cnt_d;
            cmd_word_q    <= cmd_word_d;
            illegal_q     <= illegal_d;
            init_q        <= 1'b1;
            wr_cmd_q      <= wr_cmd_d;
            wr_data_q     <= wr_data_d;
            command_out_q <= command_out_d;
            data_out_q    <= data_out_d;
            rd_en_q       <= rd_en_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_status_q <= resp_status_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
        end
    end

    assign wr_en_fifo_command = wr_cmd_q;
    assign wr_en_fifo_data    = wr_data_q;
    assign command_out        = command_out_q;
    assign data_out           = data_out_q;
    assign rd_en_output_fifo  = rd_en_q;
    assign resp_valid         = resp_valid_q;
    assign resp_result        = resp_result_q;
    assign resp_status        = resp_status_q;
    assign busy               = busy_q;
    assign err_opcode         = err_q;

endmodule

// File: tb/tb_command_issue_fsm.sv
// Directed bench for command_issue_fsm: table of descriptors with hand-computed
// command words and counts, plus cycle-exact sequences for timing and reset.
module tb_command_issue_fsm;
    import command_issue_fsm_pkg::*;

    localparam int WS = 16;
    localparam int BS = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              host_valid, host_ready;
    logic [7:0]        host_opcode;
    logic [2:0]        host_arg1;
    logic [4:0]        host_arg2;
    logic              pl_valid, pl_ready;
    logic [WS-1:0]     pl_data;
    logic [WS-1:0]     pop_in_fifo_command, pop_in_fifo_data;
    logic              wr_en_fifo_command, wr_en_fifo_data;
    logic [WS-1:0]     command_out, data_out;
    logic [WS-1:0]     pop_out_fifo;
    logic              rd_en_output_fifo;
    logic [2*WS-1:0]   result_in = '0, status_in = '0;
    logic              resp_valid, resp_ready;
    logic [2*WS-1:0]   resp_result, resp_status;
    logic              busy, err_opcode;

    always #5 clk = ~clk;

    command_issue_fsm #(.word_size(WS), .buffer_size(BS)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .host_valid          (host_valid),
        .host_ready          (host_ready),
        .host_opcode         (host_opcode),
        .host_arg1           (host_arg1),
        .host_arg2           (host_arg2),
        .pl_valid            (pl_valid),
        .pl_ready            (pl_ready),
        .pl_data             (pl_data),
        .pop_in_fifo_command (pop_in_fifo_command),
        .pop_in_fifo_data    (pop_in_fifo_data),
        .wr_en_fifo_command  (wr_en_fifo_command),
        .wr_en_fifo_data     (wr_en_fifo_data),
        .command_out         (command_out),
        .data_out            (data_out),
        .pop_out_fifo        (pop_out_fifo),
        .rd_en_output_fifo   (rd_en_output_fifo),
        .result_in           (result_in),
        .status_in           (status_in),
        .resp_valid          (resp_valid),
        .resp_ready          (resp_ready),
        .resp_result         (resp_result),
        .resp_status         (resp_status),
        .busy                (busy),
        .err_opcode          (err_opcode)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Output FIFO model and write/response logs; cumulative so only one process writes each.
    logic [2*WS-1:0] res_mem [512];
    logic [2*WS-1:0] sts_mem [512];
    logic [8:0]      loaded = '0;
    logic [8:0]      rd_ptr = '0;
    logic [WS-1:0]   cmd_mem  [512];
    logic [WS-1:0]   data_mem [512];
    logic [2*WS-1:0] got_res  [512];
    logic [2*WS-1:0] got_sts  [512];
    logic [8:0]      cmd_cnt = '0, data_cnt = '0, rsp_cnt = '0, err_cnt = '0;
    logic [8:0]      fifo_lvl;

    assign fifo_lvl     = loaded - rd_ptr;
    assign pop_out_fifo = WS'(fifo_lvl);

    always @(posedge clk) begin
        if (wr_en_fifo_command) begin
            cmd_mem[cmd_cnt] <= command_out;
            cmd_cnt          <= cmd_cnt + 9'd1;
        end
        if (wr_en_fifo_data) begin
            data_mem[data_cnt] <= data_out;
            data_cnt           <= data_cnt + 9'd1;
        end
        if (rd_en_output_fifo) begin
            result_in <= res_mem[rd_ptr];
            status_in <= sts_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 9'd1;
        end
        if (resp_valid && resp_ready) begin
            got_res[rsp_cnt] <= resp_result;
            got_sts[rsp_cnt] <= resp_status;
            rsp_cnt          <= rsp_cnt + 9'd1;
        end
        if (err_opcode) err_cnt <= err_cnt + 9'd1;
    end

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  a1;
        logic [4:0]  a2;
        int          rr_mode;   // 0: resp_ready high, 1: toggling
        logic [15:0] cmd;
        int          p;
        int          r;
        int          err;
        int          stall_at;  // payload index where the data FIFO reads full for 5 cycles
    } vec_t;

    vec_t vecs[8];

    task automatic load_pair(input logic [2*WS-1:0] res, input logic [2*WS-1:0] sts);
        res_mem[loaded] = res;
        sts_mem[loaded] = sts;
        loaded = loaded + 9'd1;
    endtask

    task automatic send_desc(input logic [7:0] op, input logic [2:0] a1, input logic [4:0] a2);
        int t = 0;
        while (!host_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("host_ready_timeout", t < 100, 1);
        host_valid = 1'b1;
        host_opcode = op;
        host_arg1 = a1;
        host_arg2 = a2;
        @(negedge clk);
        host_valid = 1'b0;
    endtask

    task automatic send_payload(input int n, input logic [WS-1:0] base, input int stall_at);
        int k = 0;
        int t = 0;
        int stall = 0;
        logic stalled;
        while (k < n && t < 400) begin
            stalled = (k == stall_at) && (stall < 5);
            pop_in_fifo_data = stalled ? WS'(BS) : '0;
            pl_valid = 1'b1;
            pl_data = base + WS'(k);
            #1;
            if (stalled) begin
                check("stall_pl_ready", pl_ready, 0);
                if (stall > 0) check("stall_no_write", wr_en_fifo_data, 0);
                stall++;
            end
            if (pl_ready) k++;
            @(negedge clk);
            t++;
        end
        pl_valid = 1'b0;
        pop_in_fifo_data = '0;
        check("payload_timeout", t < 400, 1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [8:0]    c0 = cmd_cnt, d0 = data_cnt, r0 = rd_ptr, s0 = rsp_cnt, e0 = err_cnt, l0 = loaded;
        logic [WS-1:0] base = (idx == 0) ? WS'(1) : WS'(16'h1000 * idx);
        int t = 0;
        for (int i = 0; i < v.r; i++)
            load_pair(32'hA000_0000 + 32'(l0) + 32'(i), 32'h5000_0000 + 32'(l0) + 32'(i));
        resp_ready = (v.rr_mode == 0);
        send_desc(v.op, v.a1, v.a2);
        if (v.p > 0) send_payload(v.p, base, v.stall_at);
        while (!(host_ready && !busy) && t < 500) begin
            resp_ready = (v.rr_mode == 1) ? ~resp_ready : 1'b1;
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        @(negedge clk);
        check($sformatf("v%0d_done_timeout", idx), t < 500, 1);
        check($sformatf("v%0d_cmd_count", idx), 9'(cmd_cnt - c0), 1);
        check($sformatf("v%0d_cmd_word", idx), cmd_mem[c0], v.cmd);
        check($sformatf("v%0d_data_count", idx), 9'(data_cnt - d0), 9'(v.p));
        for (int k = 0; k < v.p; k++)
            check($sformatf("v%0d_data%0d", idx, k), data_mem[9'(d0 + 9'(k))], base + WS'(k));
        check($sformatf("v%0d_rd_count", idx), 9'(rd_ptr - r0), 9'(v.r));
        check($sformatf("v%0d_resp_count", idx), 9'(rsp_cnt - s0), 9'(v.r));
        for (int i = 0; i < v.r; i++) begin
            check($sformatf("v%0d_resp_res%0d", idx, i), got_res[9'(s0 + 9'(i))],
                  32'hA000_0000 + 32'(l0) + 32'(i));
            check($sformatf("v%0d_resp_sts%0d", idx, i), got_sts[9'(s0 + 9'(i))],
                  32'h5000_0000 + 32'(l0) + 32'(i));
        end
        check($sformatf("v%0d_err_count", idx), 9'(err_cnt - e0), 9'(v.err));
        check($sformatf("v%0d_idle_busy", idx), busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_host_ready"}, host_ready, 0);
        check({tag, "_pl_ready"}, pl_ready, 0);
        check({tag, "_wr_cmd"}, wr_en_fifo_command, 0);
        check({tag, "_wr_data"}, wr_en_fifo_data, 0);
        check({tag, "_rd_en"}, rd_en_output_fifo, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err_opcode, 0);
        check({tag, "_command_out"}, command_out, 0);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_resp_result"}, resp_result, 0);
        check({tag, "_resp_status"}, resp_status, 0);
    endtask

    initial begin
        //          op      a1 a2  rr cmd       p   r  err stall
        vecs[0] = '{OP_STP, 2, 3,  0, 16'h1A00, 4,  1, 0, -1};
        vecs[1] = '{OP_EVP, 1, 0,  0, 16'h0101, 1,  1, 0, -1};
        vecs[2] = '{OP_EVB, 0, 3,  1, 16'h1802, 3,  3, 0, -1};
        vecs[3] = '{OP_STP, 1, 7,  0, 16'h3900, 8,  1, 0, 3};
        vecs[4] = '{8'h07,  0, 0,  0, 16'h0007, 0,  0, 1, -1};
        vecs[5] = '{OP_RST, 5, 0,  0, 16'h0503, 0,  0, 0, -1};
        vecs[6] = '{OP_EVB, 0, 0,  0, 16'h0002, 0,  0, 0, -1};
        vecs[7] = '{OP_STP, 7, 31, 1, 16'hFF00, 32, 1, 0, -1};

        rst = 1'b0;
        host_valid = 1'b0;
        host_opcode = '0;
        host_arg1 = '0;
        host_arg2 = '0;
        pl_valid = 1'b0;
        pl_data = '0;
        pop_in_fifo_command = '0;
        pop_in_fifo_data = '0;
        resp_ready = 1'b0;

        // Reset values, then host_ready one cycle after release.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_host_ready", host_ready, 1);
        check("post_reset_busy", busy, 0);

        // Cycle-exact EVP: command latency, read latency and response hold.
        load_pair(32'h0000_00A0, 32'h0000_0001);
        send_desc(OP_EVP, 3'd1, 5'd0);
        check("evp_wr_cmd_latency", wr_en_fifo_command, 1);
        check("evp_command_out", command_out, 16'h0101);
        check("evp_host_ready_low", host_ready, 0);
        @(negedge clk);
        check("evp_wr_cmd_single", wr_en_fifo_command, 0);
        pl_valid = 1'b1;
        pl_data = 16'd5;
        #1;
        check("evp_pl_ready", pl_ready, 1);
        @(negedge clk);
        pl_valid = 1'b0;
        check("evp_wr_data", wr_en_fifo_data, 1);
        check("evp_data_out", data_out, 16'd5);
        @(negedge clk);
        check("evp_rd_en", rd_en_output_fifo, 1);
        @(negedge clk);
        check("evp_rd_en_single", rd_en_output_fifo, 0);
        check("evp_resp_valid_early", resp_valid, 0);
        @(negedge clk);
        check("evp_resp_valid", resp_valid, 1);
        check("evp_resp_result", resp_result, 32'h0000_00A0);
        check("evp_resp_status", resp_status, 32'h0000_0001);
        repeat (2) begin
            @(negedge clk);
            check("evp_resp_hold_valid", resp_valid, 1);
            check("evp_resp_hold_result", resp_result, 32'h0000_00A0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("evp_resp_done", resp_valid, 0);
        check("evp_host_ready_back", host_ready, 1);
        check("evp_busy_low", busy, 0);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset while a response is pending.
        resp_ready = 1'b0;
        load_pair(32'h1234_5678, 32'h0000_0002);
        send_desc(OP_EVP, 3'd3, 5'd0);
        send_payload(1, 16'h0077, -1);
        begin
            int t = 0;
            while (!resp_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
        end
        check("rst_resp_reached", resp_valid, 1);
        check("rst_resp_result", resp_result, 32'h1234_5678);
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_host_ready_back", host_ready, 1);
        check("midrst_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
